// File: rtl/scan_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_mux_pkg
// Purpose  : Mode encoding and width helper shared by the scan multiplexer.
// Revision : 1.0
// ============================================================================
package scan_mux_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    SCAN   = 2'b01,
    HOLD   = 2'b10,
    RSVD   = 2'b11
  } mode_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_mux_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module   : dwell_counter
// Purpose  : Counts 0..DWELL-1 while enabled and flags the terminal count.
// Revision : 1.0
// ============================================================================
module dwell_counter
  import scan_mux_pkg::*;
#(
  parameter int DWELL = 50_000_000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int              CNTW = min1_clog2(DWELL);
  localparam logic [CNTW-1:0] LAST = CNTW'(DWELL - 1);

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  // A clearing edge is a fresh start, so it never reports terminal count.
  assign tc = enable && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : scan_mux
// Purpose  : Registered channel multiplexer with manual, auto-scan and hold modes.
// Revision : 1.0
// ============================================================================
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  parameter  int DWELL = 50_000_000,
  localparam int CW    = min1_clog2(NCH)
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [NCH*WIDTH-1:0] data_in,
  input  logic [CW-1:0]        sel,
  input  logic [1:0]           mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 ch_change
);

  localparam int            NSLOT   = 1 << CW;
  localparam logic [CW:0]   NCH_W   = (CW + 1)'(NCH);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  mode_t            mode_w;
  logic [WIDTH-1:0] chan [NSLOT];
  logic             scan_q;
  logic             is_scan;
  logic             is_hold;
  logic             cnt_clear;
  logic             cnt_enable;
  logic             tc;
  logic [CW-1:0]    ch_q;
  logic [CW-1:0]    ch_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             change_q;

  assign mode_w = mode_t'(mode);
  assign is_scan = (mode_w == SCAN);
  assign is_hold = (mode_w == HOLD) || (mode_w == RSVD);

  // Unused slots of a non-power-of-2 channel set read as zero and are never selected.
  for (genvar k = 0; k < NSLOT; k++) begin : g_chan
    if (k < NCH) begin : g_live
      assign chan[k] = data_in[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  // scan_q marks "this edge continues a scan"; a first SCAN edge clears the count instead.
  assign cnt_clear  = is_scan && !scan_q;
  assign cnt_enable = is_scan && scan_q;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .tc     (tc)
  );

  always_comb begin
    ch_d = ch_q;
    case (mode_w)
      MANUAL: begin
        if ({1'b0, sel} < NCH_W) begin
          ch_d = sel;
        end
      end
      SCAN: begin
        if (tc) begin
          ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
        end
      end
      default: ch_d = ch_q;
    endcase
  end

  assign data_d = is_hold ? data_q : chan[ch_d];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      scan_q   <= 1'b0;
      ch_q     <= '0;
      data_q   <= '0;
      change_q <= 1'b0;
    end else begin
      scan_q   <= is_scan;
      ch_q     <= ch_d;
      data_q   <= data_d;
      change_q <= (ch_d != ch_q);
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign ch_change = change_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_mux
// Purpose  : Randomized and directed checks of scan_mux against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_scan_mux;

  localparam int NDUT = 4;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  sel_r = 4'd0;
  logic [31:0] din_a = 32'h44332211;
  logic [23:0] din_b = 24'h332211;
  logic [7:0]  din_c = 8'h11;
  logic [31:0] din_d = 32'h44332211;

  logic [7:0] od_a, od_b, od_c, od_d;
  logic [1:0] oc_a, oc_b, oc_d;
  logic       oc_c;
  logic       chg_a, chg_b, chg_c, chg_d;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one entry per DUT
  int m_ch   [NDUT];
  int m_data [NDUT];
  int m_age  [NDUT];
  bit m_scan [NDUT];
  bit m_chg  [NDUT];

  always #5 Clock = ~Clock;

  scan_mux #(.WIDTH(8), .NCH(4), .DWELL(3)) u_main (
    .Clock(Clock), .Resetn(Resetn), .data_in(din_a), .sel(sel_r[1:0]), .mode(mode),
    .out_data(od_a), .out_ch(oc_a), .ch_change(chg_a));
  scan_mux #(.WIDTH(8), .NCH(3), .DWELL(2)) u_n3 (
    .Clock(Clock), .Resetn(Resetn), .data_in(din_b), .sel(sel_r[1:0]), .mode(mode),
    .out_data(od_b), .out_ch(oc_b), .ch_change(chg_b));
  scan_mux #(.WIDTH(8), .NCH(1), .DWELL(2)) u_n1 (
    .Clock(Clock), .Resetn(Resetn), .data_in(din_c), .sel(sel_r[0]), .mode(mode),
    .out_data(od_c), .out_ch(oc_c), .ch_change(chg_c));
  scan_mux #(.WIDTH(8), .NCH(4), .DWELL(1)) u_d1 (
    .Clock(Clock), .Resetn(Resetn), .data_in(din_d), .sel(sel_r[1:0]), .mode(mode),
    .out_data(od_d), .out_ch(oc_d), .ch_change(chg_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nch_of(input int i);
    case (i)
      0: return 4;
      1: return 3;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int dwell_of(input int i);
    case (i)
      0: return 3;
      1: return 2;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int sel_of(input int i);
    return (i == 2) ? int'(sel_r[0]) : int'(sel_r[1:0]);
  endfunction

  function automatic int chan_of(input int i, input int k);
    logic [7:0] v;
    case (i)
      0: v = din_a[k*8 +: 8];
      1: v = din_b[k*8 +: 8];
      2: v = din_c;
      default: v = din_d[k*8 +: 8];
    endcase
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_ch[i] = 0; m_data[i] = 0; m_age[i] = 0; m_scan[i] = 1'b0; m_chg[i] = 1'b0;
    end
  endtask

  // Scan age counts SCAN edges since entry; a channel step falls on every DWELL-th one.
  task automatic model_edge();
    for (int i = 0; i < NDUT; i++) begin
      int nxt;
      nxt = m_ch[i];
      case (mode)
        2'b00: begin
          if (sel_of(i) < nch_of(i)) nxt = sel_of(i);
          m_scan[i] = 1'b0;
        end
        2'b01: begin
          if (!m_scan[i]) begin
            m_scan[i] = 1'b1;
            m_age[i] = 0;
          end else begin
            m_age[i]++;
            if (m_age[i] % dwell_of(i) == 0) nxt = (m_ch[i] + 1) % nch_of(i);
          end
        end
        default: m_scan[i] = 1'b0;
      endcase
      m_chg[i] = (nxt != m_ch[i]);
      m_ch[i] = nxt;
      if (mode < 2'b10) m_data[i] = chan_of(i, nxt);
    end
  endtask

  task automatic check_dut(input int i, input logic [7:0] d, input logic [1:0] c, input logic g);
    check($sformatf("dut%0d.data", i), 32'(d), m_data[i]);
    check($sformatf("dut%0d.ch", i), 32'(c), m_ch[i]);
    check($sformatf("dut%0d.chg", i), 32'(g), 32'(m_chg[i]));
  endtask

  task automatic check_all();
    check_dut(0, od_a, oc_a, chg_a);
    check_dut(1, od_b, oc_b, chg_b);
    check_dut(2, od_c, {1'b0, oc_c}, chg_c);
    check_dut(3, od_d, oc_d, chg_d);
  endtask

  task automatic step();
    @(posedge Clock);
    if (Resetn) model_edge();
    #1;
    check_all();
  endtask

  task automatic tick(input logic [1:0] md, input logic [3:0] s);
    @(negedge Clock);
    mode = md;
    sel_r = s;
    step();
  endtask

  task automatic rand_data();
    din_a = $urandom();
    din_b = 24'($urandom());
    din_c = 8'($urandom());
    din_d = $urandom();
  endtask

  // Called just after a rising edge: reset is pulled and checked between edges.
  task automatic async_reset_pulse();
    Resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    Resetn = 1'b1;
  endtask

  int scan_seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    int prev;
    int prev_d;
    bit n1_seen;
    n1_seen = 1'b0;

    #2;
    Resetn = 1'b0;
    #1;
    model_reset();
    check("reset.data", 32'(od_a), 32'h0);
    check("reset.ch", 32'(oc_a), 32'h0);
    check("reset.chg", 32'(chg_a), 32'h0);
    check_all();
    step();
    Resetn = 1'b1;

    // Manual select of channel 2
    tick(2'b00, 4'd2);
    check("manual.data", 32'(od_a), 32'h33);
    check("manual.ch", 32'(oc_a), 32'd2);
    check("manual.chg", 32'(chg_a), 32'd1);
    tick(2'b00, 4'd2);
    check("manual.chg_off", 32'(chg_a), 32'd0);

    // Full scan rotation including the wrap
    tick(2'b00, 4'd0);
    prev = 0;
    for (int j = 0; j < 13; j++) begin
      tick(2'b01, 4'd3);
      check($sformatf("scan.ch[%0d]", j), 32'(oc_a), 32'(scan_seq[j]));
      check($sformatf("scan.chg[%0d]", j), 32'(chg_a), 32'(scan_seq[j] != prev));
      prev = scan_seq[j];
    end

    // Hold freezes despite new data and select
    tick(2'b00, 4'd1);
    for (int j = 0; j < 4; j++) begin
      rand_data();
      tick((j % 2 == 0) ? 2'b10 : 2'b11, 4'($urandom_range(0, 3)));
      check("hold.data", 32'(od_a), 32'h22);
      check("hold.ch", 32'(oc_a), 32'd1);
    end
    for (int j = 0; j < 4; j++) begin
      tick(2'b01, 4'd0);
      check($sformatf("hold_exit.ch[%0d]", j), 32'(oc_a), (j < 3) ? 32'd1 : 32'd2);
    end

    // Reset in the middle of a scan at channel 2
    async_reset_pulse();
    check("areset.ch", 32'(oc_a), 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick(2'b01, 4'd0);
      check($sformatf("areset_scan.ch[%0d]", j), 32'(oc_a), (j < 3) ? 32'd0 : 32'd1);
    end

    // NCH=3 rejects an out-of-range select
    tick(2'b00, 4'd1);
    tick(2'b00, 4'd3);
    check("n3.sel3_hold", 32'(oc_b), 32'd1);

    // DWELL=1 advances on each continuing SCAN edge
    tick(2'b01, 4'd0);
    prev_d = int'(oc_d);
    for (int j = 0; j < 5; j++) begin
      tick(2'b01, 4'd0);
      check("d1.advance", 32'(oc_d), 32'((prev_d + 1) % 4));
      prev_d = int'(oc_d);
    end

    // Randomized run with persistent modes and occasional resets
    for (int j = 0; j < 500; j++) begin
      logic [1:0] md;
      md = mode;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: md = 2'b00;
          3, 4, 5, 6, 7: md = 2'b01;
          8: md = 2'b10;
          default: md = 2'b11;
        endcase
      end
      rand_data();
      tick(md, 4'($urandom_range(0, 3)));
      if (chg_c) n1_seen = 1'b1;
      if ($urandom_range(0, 99) == 0) async_reset_pulse();
    end
    check("n1.never_change", 32'(n1_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bits per channel.
REQ-002 The block SHALL have parameter NCH, default 4, giving the channel count (legal values 1..16).
REQ-003 The block SHALL have parameter DWELL, default 50_000_000, giving the clock cycles per channel in scan mode (legal values 1 or more).
REQ-004 The block SHALL define a local constant CW = max(1, clog2(NCH)).
REQ-005 Clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 Resetn  input  1  asynchronous, active-low reset.
REQ-007 data_in  input  NCH*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  CW  manual channel select.
REQ-009 mode  input  2  encoding: 00 MANUAL, 01 SCAN, 10 HOLD, 11 reserved (behaves as HOLD).
REQ-010 out_data  output  WIDTH  registered selected channel data.
REQ-011 out_ch  output  CW  registered index of the currently selected channel.
REQ-012 ch_change  output  1  one-cycle pulse when out_ch changes value.

Function
REQ-013 All outputs SHALL be registered; out_data SHALL equal the value of data_in channel out_ch sampled on the previous edge (latency 1 cycle).
REQ-014 MANUAL: each edge SHALL load out_ch <= sel and out_data <= data_in[sel], provided sel < NCH.
REQ-015 MANUAL with sel >= NCH (non-power-of-2 NCH only): out_ch SHALL hold, and out_data SHALL keep tracking data_in[out_ch].
REQ-016 SCAN: the dwell counter SHALL count 0..DWELL-1; at terminal count, out_ch SHALL advance by 1 (NCH-1 wraps to 0), the counter SHALL return to 0, and out_data SHALL load the new channel on the same edge.
REQ-017 SCAN: between advances, out_data SHALL track data_in[out_ch] every cycle.
REQ-018 Entering SCAN from any other mode SHALL clear the counter to 0 on the first SCAN edge and start from the current out_ch; the first advance SHALL occur exactly DWELL cycles later.
REQ-019 HOLD (including reserved code 11): out_data, out_ch and the counter SHALL all be frozen; data_in and sel SHALL be ignored.
REQ-020 Leaving HOLD for MANUAL SHALL load sel on the first MANUAL edge.
REQ-021 Leaving HOLD for SCAN SHALL follow REQ-018; a frozen partial count SHALL NOT be resumed.
REQ-022 ch_change SHALL be 1 in exactly the cycle after an edge at which out_ch took a value different from its previous value, in any mode, and 0 otherwise.
REQ-023 NCH=1: out_ch SHALL stay 0 and ch_change SHALL never assert.
REQ-024 DWELL=1: out_ch SHALL advance on every SCAN edge.
REQ-025 A mode change and a terminal count on the same edge: the new mode SHALL govern that edge.

Reset
REQ-026 Resetn low SHALL immediately, without waiting for Clock, force out_data=0, out_ch=0, ch_change=0 and counter=0.
REQ-027 Reset asserted mid-scan SHALL abort the dwell; after release in SCAN, scanning SHALL restart at channel 0 with a full DWELL.
REQ-028 The first edge after Resetn rises SHALL behave per the current mode, with no extra cycle of latency.

Structure
REQ-029 Package scan_mux_pkg SHALL hold the mode_t enum (MANUAL, SCAN, HOLD, RSVD).
REQ-030 One sub-module, dwell_counter (parameter DWELL; inputs clear and enable; output tc), SHALL implement the counter and its terminal-count pulse.
REQ-031 Channel extraction SHALL be an indexed part-select loop, not a hand-enumerated per-bit expression.

Verification (WIDTH=8, NCH=4, DWELL=3; data_in = {8'h44, 8'h33, 8'h22, 8'h11})
REQ-032 Manual: mode=00, sel=2 -> one edge later out_data=8'h33, out_ch=2, ch_change=1 for one cycle.
REQ-033 Scan: mode=01 from out_ch=0 -> out_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; ch_change pulses on each step, including the 3->0 wrap.
REQ-034 Hold: mode=10 at out_ch=1, then change data_in and sel -> out_data stays 8'h22 and out_ch stays 1; on return to 01, the first advance occurs 3 cycles later.
REQ-035 Async reset: pull Resetn low between edges during SCAN at out_ch=2 -> outputs zero without a Clock edge; after release, the channel 0 dwell lasts 3 cycles.
REQ-036 Parameter sweep: NCH=3, sel=3 -> out_ch holds; NCH=1 -> ch_change never asserts; DWELL=1 -> out_ch advances every cycle.
